// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared definitions for the carry-save accumulator controller:
//   - STATE_W / state_t : FSM state encoding (IDLE, ACCUM, RESOLVE, DONE)
//   - DEF_DATA_W, DEF_ACC_W, DEF_CNT_W : default width constants
// ---------------------------------------------------------------------------
package csa_pkg;

  localparam int STATE_W    = 2;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_ACC_W  = 8;
  localparam int DEF_CNT_W  = 5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage : csa_pkg

// File: rtl/csa3_compress.sv
// ---------------------------------------------------------------------------
// csa3_compress
// Purely combinational bitwise 3:2 carry-save compressor.
// Ports:
//   a_i, b_i, c_i : W-bit addends
//   sum_o         : bitwise sum (a ^ b ^ c)
//   carry_o       : majority vector already shifted left by one (bit 0 = 0)
//   cout_o        : majority bit of the MSB, i.e. the carry shifted out
// Invariant: a + b + c == sum_o + carry_o + (cout_o << W)
// ---------------------------------------------------------------------------
module csa3_compress
  import csa_pkg::*;
#(
  parameter int W = DEF_ACC_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o,
  output logic         cout_o
);

  logic [W-1:0] maj;

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign carry_o = {maj[W-2:0], 1'b0};
  assign cout_o  = maj[W-1];

endmodule : csa3_compress

// File: rtl/csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// csa_accum_ctrl
// Sequential multi-operand accumulator. A command gives the operand count,
// operands stream in and are folded into redundant sum/carry form through a
// single 3:2 compressor, one carry-propagate resolve cycle follows, and the
// result is offered on a valid/ready handshake. Result is modulo 2^ACC_W.
//
// Optional feature macro: CSA_OVF_EN
//   defined   -> ovf_o port exists; sticky flag set when the true sum
//                reaches 2^ACC_W, cleared on each accepted start.
//   undefined -> no ovf_o port, no flag logic.
//
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   start_i, n_ops_i  : command valid / operand count
//   start_ready_o     : high only in IDLE
//   in_valid_i, in_data_i, in_ready_o : operand stream (ready only in ACCUM)
//   res_valid_o, res_data_o, res_ready_i : result handshake (valid only in DONE)
//   ovf_o             : overflow flag (CSA_OVF_EN only)
// ---------------------------------------------------------------------------
module csa_accum_ctrl
  import csa_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_ops_i,
  output logic              start_ready_o,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              res_valid_o,
  output logic [ACC_W-1:0]  res_data_o,
  input  logic              res_ready_i
`ifdef CSA_OVF_EN
  ,
  output logic              ovf_o
`endif
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [ACC_W-1:0]   carry_q, carry_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [ACC_W-1:0]   res_q, res_d;

  logic [ACC_W-1:0]   op_ext;
  logic [ACC_W-1:0]   csa_sum;
  logic [ACC_W-1:0]   csa_carry;
  logic [ACC_W-1:0]   resolve_sum;

`ifdef CSA_OVF_EN
  logic               ovf_q, ovf_d;
  logic               csa_cout;
  logic               resolve_cout;
  logic [ACC_W:0]     resolve_full;
`else
  logic               csa_cout_unused;
`endif

  assign op_ext = ACC_W'(in_data_i);

  csa3_compress #(
    .W (ACC_W)
  ) u_csa (
    .a_i     (sum_q),
    .b_i     (carry_q),
    .c_i     (op_ext),
    .sum_o   (csa_sum),
    .carry_o (csa_carry),
`ifdef CSA_OVF_EN
    .cout_o  (csa_cout)
`else
    .cout_o  (csa_cout_unused)
`endif
  );

  // Carry-propagate resolve of the redundant pair.
`ifdef CSA_OVF_EN
  assign resolve_full = {1'b0, sum_q} + {1'b0, carry_q};
  assign resolve_sum  = resolve_full[ACC_W-1:0];
  assign resolve_cout = resolve_full[ACC_W];
`else
  assign resolve_sum  = sum_q + carry_q;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset discards any partial sum of an aborted command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q   <= '0;
      carry_q <= '0;
      rem_q   <= '0;
      res_q   <= '0;
`ifdef CSA_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
`ifdef CSA_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    res_d   = res_q;
`ifdef CSA_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rem_d   = n_ops_i;
          sum_d   = '0;
          carry_d = '0;
`ifdef CSA_OVF_EN
          ovf_d   = 1'b0;
`endif
          // An empty command skips straight to resolve and returns 0.
          state_d = (n_ops_i != '0) ? S_ACCUM : S_RESOLVE;
        end
      end
      S_ACCUM: begin
        if (in_valid_i) begin
          sum_d   = csa_sum;
          carry_d = csa_carry;
          rem_d   = rem_q - 1'b1;
`ifdef CSA_OVF_EN
          ovf_d   = ovf_q | csa_cout;
`endif
          if (rem_q == CNT_W'(1)) begin
            state_d = S_RESOLVE;
          end
        end
      end
      S_RESOLVE: begin
        res_d   = resolve_sum;
`ifdef CSA_OVF_EN
        ovf_d   = ovf_q | resolve_cout;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    start_ready_o = (state_q == S_IDLE);
    in_ready_o    = (state_q == S_ACCUM);
    res_valid_o   = (state_q == S_DONE);
  end

  assign res_data_o = res_q;
`ifdef CSA_OVF_EN
  assign ovf_o      = ovf_q;
`endif

endmodule : csa_accum_ctrl

// File: tb/tb_csa_accum_ctrl.sv
module tb_csa_accum_ctrl;

  localparam int DATA_W = 4;
  localparam int ACC_W  = 8;
  localparam int CNT_W  = 5;
  localparam int NVEC   = 8;

  logic              clk;
  logic              rst_i;
  logic              start_i;
  logic [CNT_W-1:0]  n_ops_i;
  logic              start_ready_o;
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_ready_o;
  logic              res_valid_o;
  logic [ACC_W-1:0]  res_data_o;
  logic              res_ready_i;
`ifdef CSA_OVF_EN
  logic              ovf_o;
`endif

  csa_accum_ctrl #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .n_ops_i       (n_ops_i),
    .start_ready_o (start_ready_o),
    .in_valid_i    (in_valid_i),
    .in_data_i     (in_data_i),
    .in_ready_o    (in_ready_o),
    .res_valid_o   (res_valid_o),
    .res_data_o    (res_data_o),
    .res_ready_i   (res_ready_i)
`ifdef CSA_OVF_EN
    ,
    .ovf_o         (ovf_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]   n;
    logic [123:0] ops;
    logic [7:0]   gap;
    logic [7:0]   rdly;
    logic [7:0]   exp;
    logic         ovf;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb_q [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int n, input int fill, input int gap, input int rdly,
                              input int exp, input bit ovf);
    vec_t v;
    v = '0;
    v.n = n[4:0];
    for (int i = 0; i < 31; i++) v.ops[i*4 +: 4] = fill[3:0];
    v.gap = gap[7:0];
    v.rdly = rdly[7:0];
    v.exp = exp[7:0];
    v.ovf = ovf;
    return v;
  endfunction

  task automatic wait_start_ready(input string name);
    int k;
    k = 0;
    while (!start_ready_o && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) check({name, "_start_ready_timeout"}, 0, 1);
  endtask

  task automatic check_ovf(input string name, input bit req);
`ifdef CSA_OVF_EN
    check(name, int'(ovf_o), int'(req));
`endif
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int   k;
    exp_t e;
    wait_start_ready(name);
    start_i = 1'b1;
    n_ops_i = v.n;
    tick();
    start_i = 1'b0;
    sb_q.push_back('{data: v.exp, ovf: v.ovf});
    if (v.n == 0) begin
      // Operands offered outside ACCUM must be ignored.
      in_valid_i = 1'b1;
      in_data_i  = 4'd15;
      check({name, "_no_inready"}, int'(in_ready_o), 0);
    end
    for (int i = 0; i < int'(v.n); i++) begin
      in_valid_i = 1'b1;
      in_data_i  = v.ops[i*4 +: 4];
      k = 0;
      while (!in_ready_o && k < 20) begin
        tick();
        k++;
      end
      if (k >= 20) check({name, "_in_ready_timeout"}, 0, 1);
      tick();
      in_valid_i = 1'b0;
      if (i < int'(v.n) - 1) repeat (int'(v.gap)) tick();
    end
    // Exact latency: RESOLVE right after the last accept, DONE one cycle later.
    check({name, "_lat_resolve"}, int'(res_valid_o), 0);
    tick();
    in_valid_i = 1'b0;
    check({name, "_lat_done"}, int'(res_valid_o), 1);
    for (int i = 0; i < int'(v.rdly); i++) begin
      check({name, "_hold_valid"}, int'(res_valid_o), 1);
      check({name, "_hold_data"}, int'(res_data_o), int'(v.exp));
      tick();
    end
    res_ready_i = 1'b1;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({name, "_data"}, int'(res_data_o), int'(e.data));
      check_ovf({name, "_ovf"}, e.ovf);
    end
    tick();
    res_ready_i = 1'b0;
    check({name, "_valid_fall"}, int'(res_valid_o), 0);
    check({name, "_idle"}, int'(start_ready_o), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    n_ops_i     = '0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    res_ready_i = 1'b0;

    vecs[0] = mk(4, 15, 0, 0, 60, 1'b0);
    vecs[1] = mk(3, 0, 2, 5, 6, 1'b0);
    vecs[1].ops[3:0]  = 4'd1;
    vecs[1].ops[7:4]  = 4'd2;
    vecs[1].ops[11:8] = 4'd3;
    vecs[2] = mk(18, 15, 0, 1, 14, 1'b1);
    vecs[3] = mk(0, 0, 0, 2, 0, 1'b0);
    vecs[4] = mk(31, 15, 0, 0, 209, 1'b1);
    vecs[5] = mk(5, 0, 1, 0, 0, 1'b0);
    vecs[6] = mk(17, 15, 0, 0, 255, 1'b0);
    vecs[7] = mk(1, 9, 0, 1, 9, 1'b0);

    repeat (3) tick();
    rst_i = 1'b0;
    check("rst_start_ready", int'(start_ready_o), 1);
    check("rst_in_ready", int'(in_ready_o), 0);
    check("rst_res_valid", int'(res_valid_o), 0);
    check("rst_res_data", int'(res_data_o), 0);
    check_ovf("rst_ovf", 1'b0);

    for (int i = 0; i < NVEC; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Start pulses during ACCUM and on the DONE handshake are ignored.
    wait_start_ready("ign");
    start_i = 1'b1;
    n_ops_i = 5'd2;
    tick();
    n_ops_i = 5'd9;
    check("ign_accum_start_ready", int'(start_ready_o), 0);
    in_valid_i = 1'b1;
    in_data_i  = 4'd5;
    tick();
    start_i   = 1'b0;
    in_data_i = 4'd6;
    tick();
    in_valid_i = 1'b0;
    check("ign_resolve", int'(res_valid_o), 0);
    tick();
    check("ign_done_valid", int'(res_valid_o), 1);
    check("ign_done_data", int'(res_data_o), 11);
    check("ign_done_start_ready", int'(start_ready_o), 0);
    start_i     = 1'b1;
    n_ops_i     = 5'd3;
    res_ready_i = 1'b1;
    tick();
    start_i     = 1'b0;
    res_ready_i = 1'b0;
    check("ign_after_hs_idle", int'(start_ready_o), 1);
    check("ign_after_hs_valid", int'(res_valid_o), 0);
    tick();
    check("ign_still_idle", int'(start_ready_o), 1);
    check("ign_no_accum", int'(in_ready_o), 0);

    // Reset in the middle of a transaction aborts it.
    start_i = 1'b1;
    n_ops_i = 5'd5;
    tick();
    start_i    = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = 4'd9;
    tick();
    tick();
    in_valid_i = 1'b0;
    check("abort_in_accum", int'(in_ready_o), 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("abort_start_ready", int'(start_ready_o), 1);
    check("abort_in_ready", int'(in_ready_o), 0);
    check("abort_res_valid", int'(res_valid_o), 0);
    check("abort_res_data", int'(res_data_o), 0);
    check_ovf("abort_ovf", 1'b0);
    v = mk(2, 0, 0, 0, 15, 1'b0);
    v.ops[3:0] = 4'd7;
    v.ops[7:4] = 4'd8;
    run_vec("after_abort", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_csa_accum_ctrl
